// File: rtl/garage_door_timed_pkg.sv
// Shared types and default parameter values for the timed garage door controller.
package garage_pkg;

  typedef enum logic [2:0] {
    ST_CLOSED    = 3'd0,
    ST_OPEN      = 3'd1,
    ST_MOVE_UP   = 3'd2,
    ST_MOVE_DOWN = 3'd3,
    ST_PAUSE_UP  = 3'd4,
    ST_PAUSE_DN  = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam int unsigned DEF_DEB_CYCLES   = 16;
  localparam int unsigned DEF_MOVE_TIMEOUT = 1000;
  localparam int unsigned DEF_AUTO_CLOSE   = 500;
  localparam int unsigned DEF_REV_PAUSE    = 8;
  localparam int unsigned DEF_BLINK_HALF   = 4;

  // Counter width able to hold p; at least one bit so a disabled feature still elaborates.
  function automatic int unsigned cnt_w(input int unsigned p);
    return (p == 0) ? 1 : int'($clog2(p + 1));
  endfunction

endpackage

// File: rtl/garage_door_timed_button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, consecutive-sample debounce, rising-edge pulse.
module button_debounce
  import garage_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = cnt_w(DEB_CYCLES);

  logic [1:0]    sync_q, sync_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // Level flips only after DEB_CYCLES consecutive samples disagree with it.
  always_comb begin
    sync_d = {sync_q[0], btn};
    deb_d  = deb_q;
    cnt_d  = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    pulse_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/garage_door_timed.sv
// Timed garage door controller: button/sensor conditioning, motion FSM with dead time,
// move timeout, auto-close and blinking warning light.
module garage_door_timed
  import garage_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int unsigned MOVE_TIMEOUT = DEF_MOVE_TIMEOUT,
  parameter int unsigned AUTO_CLOSE   = DEF_AUTO_CLOSE,
  parameter int unsigned REV_PAUSE    = DEF_REV_PAUSE,
  parameter int unsigned BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic       clk50m,
  input  logic       rst_n,
  input  logic       up,
  input  logic       dn,
  input  logic       top,
  input  logic       bottom,
  input  logic       lb,
  input  logic       ack,
  output logic       left,
  output logic       right,
  output logic       wl,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam int unsigned MW = cnt_w(MOVE_TIMEOUT);
  localparam int unsigned AW = cnt_w(AUTO_CLOSE);
  localparam int unsigned PW = cnt_w(REV_PAUSE);
  localparam int unsigned BW = cnt_w(BLINK_HALF);

  state_t        state_q, state_d;
  logic [3:0]    sens_meta_q, sens_meta_d;
  logic [3:0]    sens_sync_q, sens_sync_d;
  logic [MW-1:0] mv_cnt_q, mv_cnt_d;
  logic [AW-1:0] ac_cnt_q, ac_cnt_d;
  logic [PW-1:0] pause_cnt_q, pause_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          wl_q, wl_d;
  logic          left_q, left_d;
  logic          right_q, right_d;
  logic          fault_q, fault_d;

  logic up_p, dn_p;
  logic top_s, bottom_s, lb_s, ack_s;
  logic changed, mv_timeout, ac_done, pause_done;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up_deb (
    .clk   (clk50m),
    .rst_n (rst_n),
    .btn   (up),
    .pulse (up_p)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn_deb (
    .clk   (clk50m),
    .rst_n (rst_n),
    .btn   (dn),
    .pulse (dn_p)
  );

  assign top_s    = sens_sync_q[0];
  assign bottom_s = sens_sync_q[1];
  assign lb_s     = sens_sync_q[2];
  assign ack_s    = sens_sync_q[3];

  // Next state, dwell counters and registered Moore outputs.
  always_comb begin
    sens_meta_d = {ack, lb, bottom, top};
    sens_sync_d = sens_meta_q;
    state_d     = state_q;
    mv_timeout  = (mv_cnt_q == MW'(MOVE_TIMEOUT - 1));
    ac_done     = (AUTO_CLOSE != 0) && (ac_cnt_q == AW'(AUTO_CLOSE - 1));
    pause_done  = (pause_cnt_q == PW'(REV_PAUSE - 1));

    unique case (state_q)
      ST_CLOSED:    if (up_p && !dn_p) state_d = ST_PAUSE_UP;
      ST_OPEN:      if (!lb_s && ((dn_p && !up_p) || ac_done)) state_d = ST_PAUSE_DN;
      ST_MOVE_UP: begin
        if (top_s && bottom_s)  state_d = ST_FAULT;
        else if (top_s)         state_d = ST_OPEN;
        else if (mv_timeout)    state_d = ST_FAULT;
        else if (dn_p)          state_d = ST_PAUSE_DN;
      end
      ST_MOVE_DOWN: begin
        if (top_s && bottom_s)  state_d = ST_FAULT;
        else if (bottom_s)      state_d = ST_CLOSED;
        else if (lb_s || up_p)  state_d = ST_PAUSE_UP;
        else if (mv_timeout)    state_d = ST_FAULT;
      end
      ST_PAUSE_UP:  if (pause_done) state_d = ST_MOVE_UP;
      ST_PAUSE_DN: begin
        if (lb_s)               state_d = ST_PAUSE_UP;
        else if (pause_done)    state_d = ST_MOVE_DOWN;
      end
      ST_FAULT:     if (ack_s) state_d = ST_PAUSE_UP;
      default:      state_d = ST_PAUSE_DN;
    endcase

    changed = (state_d != state_q);

    // Dwell counters restart on any state change and saturate instead of wrapping.
    mv_cnt_d = '0;
    if (!changed && (state_q == ST_MOVE_UP || state_q == ST_MOVE_DOWN) &&
        mv_cnt_q != MW'(MOVE_TIMEOUT)) begin
      mv_cnt_d = mv_cnt_q + MW'(1);
    end
    ac_cnt_d = '0;
    if (!changed && state_q == ST_OPEN && !lb_s && ac_cnt_q != AW'(AUTO_CLOSE)) begin
      ac_cnt_d = ac_cnt_q + AW'(1);
    end
    pause_cnt_d = '0;
    if (!changed && (state_q == ST_PAUSE_UP || state_q == ST_PAUSE_DN) &&
        pause_cnt_q != PW'(REV_PAUSE)) begin
      pause_cnt_d = pause_cnt_q + PW'(1);
    end

    wl_d        = 1'b1;
    blink_cnt_d = '0;
    case (state_d)
      ST_OPEN, ST_CLOSED: wl_d = 1'b0;
      ST_MOVE_UP, ST_MOVE_DOWN: begin
        if (!changed) begin
          if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            wl_d = ~wl_q;
          end else begin
            wl_d        = wl_q;
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
      end
      default: ;
    endcase

    left_d  = (state_d == ST_MOVE_UP);
    right_d = (state_d == ST_MOVE_DOWN);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PAUSE_DN;
      sens_meta_q <= '0;
      sens_sync_q <= '0;
      mv_cnt_q    <= '0;
      ac_cnt_q    <= '0;
      pause_cnt_q <= '0;
      blink_cnt_q <= '0;
      wl_q        <= 1'b1;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sens_meta_q <= sens_meta_d;
      sens_sync_q <= sens_sync_d;
      mv_cnt_q    <= mv_cnt_d;
      ac_cnt_q    <= ac_cnt_d;
      pause_cnt_q <= pause_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      wl_q        <= wl_d;
      left_q      <= left_d;
      right_q     <= right_d;
      fault_q     <= fault_d;
    end
  end

  assign left    = left_q;
  assign right   = right_q;
  assign wl      = wl_q;
  assign fault   = fault_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_garage_door_timed.sv
// Scoreboard bench: a timestamp-based reference model queues expected outputs per cycle,
// a monitor pops and compares them on the falling edge.
module tb_garage_door_timed;
  import garage_pkg::*;

  localparam int DEB = 4;
  localparam int MT  = 50;
  localparam int AC  = 20;
  localparam int RP  = 3;
  localparam int BH  = 2;

  logic clk50m = 1'b0;
  logic rst_n  = 1'b0;
  logic up = 1'b0, dn = 1'b0, top = 1'b0, bottom = 1'b0, lb = 1'b0, ack = 1'b0;
  logic left, right, wl, fault;
  logic [2:0] state_o;

  garage_door_timed #(
    .DEB_CYCLES(DEB), .MOVE_TIMEOUT(MT), .AUTO_CLOSE(AC), .REV_PAUSE(RP), .BLINK_HALF(BH)
  ) dut (
    .clk50m (clk50m), .rst_n (rst_n),
    .up (up), .dn (dn), .top (top), .bottom (bottom), .lb (lb), .ack (ack),
    .left (left), .right (right), .wl (wl), .fault (fault), .state_o (state_o)
  );

  always #5 clk50m = ~clk50m;

  typedef struct packed {
    logic [2:0] st;
    logic       left;
    logic       right;
    logic       wl;
    logic       fault;
  } exp_t;

  typedef bit bq_t[$];

  exp_t   exp_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     to_req = 0;
  int     to_seen = 0;

  // Reference model state: entry timestamps instead of counters.
  state_t ms = ST_PAUSE_DN;
  state_t nxt;
  int     cyc = 0, entry = 0, ac_ref = 0, n;
  logic [5:0] r1 = '0, r2 = '0, s;
  bq_t    up_win, dn_win;
  bit     up_deb = 0, dn_deb = 0, up_p_m = 0, dn_p_m = 0, upp, dnp;
  bit     e_wl;

  function automatic bit win_all(input bq_t w, input bit v);
    foreach (w[i]) if (w[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void cmp(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Reference model: one step per rising edge, inputs seen two edges late, pulses one more.
  initial forever begin
    @(posedge clk50m or negedge rst_n);
    if (!rst_n) begin
      ms = ST_PAUSE_DN; cyc = 0; entry = 0; ac_ref = 0; r1 = '0; r2 = '0;
      up_win.delete(); dn_win.delete();
      up_deb = 0; dn_deb = 0; up_p_m = 0; dn_p_m = 0;
      exp_q.delete();
    end else begin
      cyc++;
      s  = r2;
      r2 = r1;
      r1 = {ack, lb, bottom, top, dn, up};
      upp = up_p_m;
      dnp = dn_p_m;
      up_win.push_back(s[0]);
      if (up_win.size() > DEB) void'(up_win.pop_front());
      dn_win.push_back(s[1]);
      if (dn_win.size() > DEB) void'(dn_win.pop_front());
      up_p_m = 0;
      dn_p_m = 0;
      if (up_win.size() == DEB && win_all(up_win, !up_deb)) begin up_deb = !up_deb; up_p_m = up_deb; end
      if (dn_win.size() == DEB && win_all(dn_win, !dn_deb)) begin dn_deb = !dn_deb; dn_p_m = dn_deb; end

      n   = cyc - entry - 1;
      nxt = ms;
      case (ms)
        ST_CLOSED: if (upp && !dnp) nxt = ST_PAUSE_UP;
        ST_OPEN: begin
          if (s[4]) ac_ref = cyc;
          else if ((dnp && !upp) || (cyc - ac_ref - 1 == AC - 1)) nxt = ST_PAUSE_DN;
        end
        ST_MOVE_UP: begin
          if (s[2] && s[3]) nxt = ST_FAULT;
          else if (s[2]) nxt = ST_OPEN;
          else if (n == MT - 1) nxt = ST_FAULT;
          else if (dnp) nxt = ST_PAUSE_DN;
        end
        ST_MOVE_DOWN: begin
          if (s[2] && s[3]) nxt = ST_FAULT;
          else if (s[3]) nxt = ST_CLOSED;
          else if (s[4] || upp) nxt = ST_PAUSE_UP;
          else if (n == MT - 1) nxt = ST_FAULT;
        end
        ST_PAUSE_UP: if (n == RP - 1) nxt = ST_MOVE_UP;
        ST_PAUSE_DN: begin
          if (s[4]) nxt = ST_PAUSE_UP;
          else if (n == RP - 1) nxt = ST_MOVE_DOWN;
        end
        ST_FAULT: if (s[5]) nxt = ST_PAUSE_UP;
        default: nxt = ST_PAUSE_DN;
      endcase
      if (nxt != ms) begin
        entry  = cyc;
        ac_ref = cyc;
        ms     = nxt;
      end
      if (ms == ST_MOVE_UP || ms == ST_MOVE_DOWN) e_wl = (((cyc - entry) / BH) % 2) == 0;
      else e_wl = !(ms == ST_OPEN || ms == ST_CLOSED);
      exp_q.push_back('{st: ms, left: (ms == ST_MOVE_UP), right: (ms == ST_MOVE_DOWN),
                        wl: e_wl, fault: (ms == ST_FAULT)});
    end
  end

  // Monitor: reset values while rst_n is low, otherwise one queued expectation per cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk50m or negedge rst_n);
      #1;
      cmp("motor_exclusive", int'(left & right), 0);
      if (!rst_n) begin
        cmp("rst_left", int'(left), 0);
        cmp("rst_right", int'(right), 0);
        cmp("rst_wl", int'(wl), 1);
        cmp("rst_fault", int'(fault), 0);
        cmp("rst_state", int'(state_o), int'(ST_PAUSE_DN));
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("state_o", int'(state_o), int'(e.st));
        cmp("left", int'(left), int'(e.left));
        cmp("right", int'(right), int'(e.right));
        cmp("wl", int'(wl), int'(e.wl));
        cmp("fault", int'(fault), int'(e.fault));
      end
      if (to_req != to_seen) begin
        to_seen = to_req;
        cmp("wait_budget", 1, 0);
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(posedge clk50m);
    #2;
  endtask

  task automatic wait_model(input state_t st, input int budget);
    int i = 0;
    while (ms != st && i < budget) begin
      cycles(1);
      i++;
    end
    if (ms != st) to_req++;
  endtask

  task automatic press(input bit u, input bit d, input int hold);
    bit v;
    for (int i = 0; i < 3; i++) begin
      v = 1'($urandom_range(0, 1));
      if (u) up = v;
      if (d) dn = v;
      cycles(1);
    end
    if (u) up = 1'b1;
    if (d) dn = 1'b1;
    cycles(hold);
    if (u) up = 1'b0;
    if (d) dn = 1'b0;
    cycles(DEB + 4);
  endtask

  task automatic reset_pulse();
    #1;
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    bottom = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    wait_model(ST_MOVE_DOWN, 10);
    wait_model(ST_CLOSED, 10);

    press(1, 0, 12);
    wait_model(ST_MOVE_UP, 40);
    cycles(3); bottom = 1'b0;
    cycles(8); top = 1'b1;
    wait_model(ST_OPEN, 20);

    lb = 1'b1; cycles(40); lb = 1'b0;
    wait_model(ST_PAUSE_DN, 30);
    wait_model(ST_MOVE_DOWN, 10);
    cycles(2); top = 1'b0;
    cycles(3); lb = 1'b1;
    wait_model(ST_PAUSE_UP, 10);
    cycles(3); lb = 1'b0;
    wait_model(ST_MOVE_UP, 10);
    wait_model(ST_FAULT, 60);
    cycles(3); ack = 1'b1;
    wait_model(ST_PAUSE_UP, 10);
    ack = 1'b0;
    wait_model(ST_MOVE_UP, 10);
    cycles(2); top = 1'b1; bottom = 1'b1;
    wait_model(ST_FAULT, 10);
    bottom = 1'b0;
    cycles(3); ack = 1'b1; cycles(4); ack = 1'b0;
    wait_model(ST_OPEN, 20);

    press(1, 1, 10);
    press(0, 1, 8);
    wait_model(ST_MOVE_DOWN, 40);
    top = 1'b0;
    cycles(2);
    reset_pulse();
    wait_model(ST_MOVE_DOWN, 10);
    cycles(6); bottom = 1'b1;
    wait_model(ST_CLOSED, 10);
    press(1, 1, 10);

    for (int seg = 0; seg < 120; seg++) begin
      case ($urandom_range(0, 7))
        0: press(1, 0, $urandom_range(1, 10));
        1: press(0, 1, $urandom_range(1, 10));
        2: press(1, 1, $urandom_range(2, 10));
        3: begin lb = 1'b1; cycles($urandom_range(1, 30)); lb = 1'b0; end
        4: begin ack = 1'b1; cycles($urandom_range(1, 4)); ack = 1'b0; end
        5: begin
          case ($urandom_range(0, 5))
            0: begin top = 1'b1; bottom = 1'b1; end
            1, 2: begin top = 1'b1; bottom = 1'b0; end
            3, 4: begin top = 1'b0; bottom = 1'b1; end
            default: begin top = 1'b0; bottom = 1'b0; end
          endcase
          cycles($urandom_range(1, 20));
        end
        6: cycles($urandom_range(5, 60));
        default: begin
          if ($urandom_range(0, 3) == 0) reset_pulse();
          else cycles($urandom_range(1, 10));
        end
      endcase
    end

    cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
